// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the MEM-stage AXI-Lite data master.
// Covers size codes, AXI response codes, FSM state encoding and the alignment check.
package mem_bus_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The reserved size code 3 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_B: is_misaligned = 1'b0;
      MEM_SIZE_H: is_misaligned = addr_lo[0];
      default:    is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the right-justified core data and the 32-bit bus.
// Produces store strobes and replicated store data, plus the shifted and extended load result.
module mem_lane_align
  import mem_bus_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    wstrb   = 4'b1111;
    wdata   = st_data;
    ld_data = '0;
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      MEM_SIZE_B: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sign & shifted[7]}}, shifted[7:0]};
      end
      MEM_SIZE_H: begin
        wstrb   = 4'b0011 << {addr_lo[1], 1'b0};
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sign & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        ld_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store sequencer onto an AXI-Lite data master, one access in flight.
// Stalls the pipeline from acceptance until the response handshake, then flags DONE for one cycle.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_sign_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              addr_err_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q, we_q, err_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q, load_data_q;
  logic              arvalid_q, awvalid_q, wvalid_q;

  logic              misaligned, accept, idle;
  logic [1:0]        al_addr, al_size;
  logic              al_sign;
  logic [3:0]        al_wstrb;
  logic [DATA_W-1:0] al_wdata, al_ld_data;

  assign idle       = (state_q == ST_IDLE);
  assign misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);
  assign accept     = idle & mem_req_i & ~misaligned;

  // Live request steers the lanes while idle; the latched access is used afterwards.
  assign al_addr = idle ? mem_addr_i[1:0] : addr_q[1:0];
  assign al_size = idle ? mem_size_i      : size_q;
  assign al_sign = idle ? mem_sign_i      : sign_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo (al_addr),
    .size    (al_size),
    .sign    (al_sign),
    .st_data (mem_wdata_i),
    .rdata   (rdata),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata),
    .ld_data (al_ld_data)
  );

  assign rready       = (state_q == ST_RD);
  assign bready       = (state_q == ST_WR) & ~awvalid_q & ~wvalid_q;
  assign stall_o      = accept | (state_q == ST_RD) | (state_q == ST_WR);
  assign addr_err_o   = mem_req_i & misaligned;
  assign load_valid_o = (state_q == ST_DONE) & ~we_q;
  assign bus_err_o    = (state_q == ST_DONE) & err_q;
  assign load_data_o  = load_data_q;
  assign awaddr       = addr_q;
  assign araddr       = addr_q;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign arvalid      = arvalid_q;
  assign awvalid      = awvalid_q;
  assign wvalid       = wvalid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = mem_we_i ? ST_WR : ST_RD;
      ST_RD:   if (rvalid & rready) state_d = ST_DONE;
      ST_WR:   if (bvalid & bready) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q      <= '0;
      size_q      <= MEM_SIZE_W;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
    end else if (accept) begin
      addr_q    <= mem_addr_i;
      size_q    <= mem_size_i;
      sign_q    <= mem_sign_i;
      we_q      <= mem_we_i;
      wstrb_q   <= al_wstrb;
      wdata_q   <= al_wdata;
      arvalid_q <= ~mem_we_i;
      awvalid_q <= mem_we_i;
      wvalid_q  <= mem_we_i;
    end else begin
      if (arvalid_q & arready) arvalid_q <= 1'b0;
      if (awvalid_q & awready) awvalid_q <= 1'b0;
      if (wvalid_q & wready)   wvalid_q  <= 1'b0;
      if (rvalid & rready) begin
        load_data_q <= al_ld_data;
        err_q       <= (rresp != RESP_OKAY);
      end
      if (bvalid & bready) err_q <= (bresp != RESP_OKAY);
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: hand-computed loads, stores, back-pressure, errors and reset.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic        clk, resetn;
  logic        mem_req, mem_we, mem_sign;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, load_valid, addr_err, bus_err;
  logic [31:0] load_data;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int vecs = 0;
  int errs = 0;

  mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size), .mem_sign_i(mem_sign),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid),
    .addr_err_o(addr_err), .bus_err_o(bus_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait slave: AR in the first RD cycle, R the cycle after.
  task automatic load_seq(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                          input logic [31:0] d, input logic [1:0] rsp,
                          input logic [31:0] exp_d, input logic exp_err);
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = sz; mem_sign = sg; mem_addr = a; arready = 1;
    #1 chk("ld_accept_stall", stall, 1);
    chk("ld_accept_addr_err", addr_err, 0);
    @(negedge clk); #1;
    chk("ld_rd_arvalid", arvalid, 1);
    chk("ld_rd_araddr", araddr, a);
    chk("ld_rd_rready", rready, 1);
    chk("ld_rd_stall", stall, 1);
    @(negedge clk);
    arready = 0; rvalid = 1; rdata = d; rresp = rsp;
    #1 chk("ld_r_arvalid_dropped", arvalid, 0);
    chk("ld_r_stall", stall, 1);
    @(negedge clk);
    rvalid = 0; rdata = 0; rresp = RESP_OKAY;
    #1 chk("ld_done_stall", stall, 0);
    chk("ld_done_valid", load_valid, 1);
    chk("ld_done_data", load_data, exp_d);
    chk("ld_done_bus_err", bus_err, exp_err);
    @(negedge clk);
    mem_req = 0;
    #1 chk("ld_after_valid", load_valid, 0);
    chk("ld_after_bus_err", bus_err, 0);
  endtask

  task automatic store_seq(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_size = sz; mem_sign = 0; mem_addr = a; mem_wdata = wd;
    awready = 1; wready = 1;
    #1 chk("st_accept_stall", stall, 1);
    @(negedge clk); #1;
    chk("st_wr_awvalid", awvalid, 1);
    chk("st_wr_wvalid", wvalid, 1);
    chk("st_wr_awaddr", awaddr, a);
    chk("st_wr_wstrb", wstrb, exp_strb);
    chk("st_wr_wdata", wdata, exp_wd);
    chk("st_wr_bready_low", bready, 0);
    @(negedge clk);
    awready = 0; wready = 0; bvalid = 1; bresp = RESP_OKAY;
    #1 chk("st_b_bready", bready, 1);
    chk("st_b_stall", stall, 1);
    @(negedge clk);
    bvalid = 0;
    #1 chk("st_done_stall", stall, 0);
    chk("st_done_load_valid", load_valid, 0);
    chk("st_done_bus_err", bus_err, 0);
    @(negedge clk);
    mem_req = 0;
  endtask

  initial begin
    resetn = 0; mem_req = 0; mem_we = 0; mem_size = 0; mem_sign = 0;
    mem_addr = 0; mem_wdata = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_ready", {30'd0, bready, rready}, 0);
    chk("rst_pulses", {30'd0, load_valid, bus_err}, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_addr", awaddr | araddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    @(negedge clk);
    resetn = 1;

    load_seq(32'h100, MEM_SIZE_W, 0, 32'h89ABCDEF, RESP_OKAY, 32'h89ABCDEF, 0);
    load_seq(32'h103, MEM_SIZE_B, 1, 32'h80FF1234, RESP_OKAY, 32'hFFFFFF80, 0);
    load_seq(32'h102, MEM_SIZE_H, 0, 32'h80FF1234, RESP_OKAY, 32'h000080FF, 0);
    load_seq(32'h102, MEM_SIZE_H, 1, 32'h80FF1234, RESP_OKAY, 32'hFFFF80FF, 0);
    load_seq(32'h101, MEM_SIZE_B, 0, 32'h80FF1234, RESP_OKAY, 32'h00000012, 0);

    store_seq(32'h201, MEM_SIZE_B, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    store_seq(32'h202, MEM_SIZE_H, 32'h00001234, 4'b1100, 32'h12341234);
    store_seq(32'h204, MEM_SIZE_W, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    // Back-pressured store: W accepted 3 cycles after AW, B 2 cycles after W.
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_size = MEM_SIZE_W; mem_addr = 32'h300; mem_wdata = 32'hDEADBEEF;
    awready = 1; wready = 0;
    #1 chk("bp_accept_stall", stall, 1);
    @(negedge clk); #1;
    chk("bp_aw_awvalid", awvalid, 1);
    chk("bp_aw_bready", bready, 0);
    @(negedge clk);
    awready = 0;
    #1 chk("bp_w1_awvalid", awvalid, 0);
    chk("bp_w1_wvalid", wvalid, 1);
    chk("bp_w1_bready", bready, 0);
    chk("bp_w1_stall", stall, 1);
    @(negedge clk); #1;
    chk("bp_w2_bready", bready, 0);
    @(negedge clk);
    wready = 1;
    #1 chk("bp_w3_wvalid", wvalid, 1);
    chk("bp_w3_bready", bready, 0);
    @(negedge clk);
    wready = 0;
    #1 chk("bp_b1_wvalid", wvalid, 0);
    chk("bp_b1_bready", bready, 1);
    chk("bp_b1_stall", stall, 1);
    @(negedge clk);
    bvalid = 1; bresp = RESP_OKAY;
    #1 chk("bp_b2_stall", stall, 1);
    @(negedge clk);
    bvalid = 0;
    #1 chk("bp_done_stall", stall, 0);
    chk("bp_done_bus_err", bus_err, 0);
    @(negedge clk);
    mem_req = 0;
    #1 chk("bp_idle_stall", stall, 0);

    // Misaligned requests never reach the bus.
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = MEM_SIZE_W; mem_addr = 32'h102; arready = 1;
    #1 chk("mis_w_addr_err", addr_err, 1);
    chk("mis_w_stall", stall, 0);
    @(negedge clk); #1;
    chk("mis_w_arvalid", arvalid, 0);
    chk("mis_w_stall_hold", stall, 0);
    mem_size = MEM_SIZE_H; mem_addr = 32'h101;
    #1 chk("mis_h_addr_err", addr_err, 1);
    mem_size = MEM_SIZE_H; mem_addr = 32'h102;
    #1 chk("ali_h_addr_err", addr_err, 0);
    mem_req = 0; mem_size = MEM_SIZE_W; mem_addr = 32'h102;
    #1 chk("mis_noreq_addr_err", addr_err, 0);
    arready = 0;

    load_seq(32'h104, MEM_SIZE_W, 0, 32'h00000000, RESP_SLVERR, 32'h00000000, 1);

    // Reset asserted while the read address is still pending.
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = MEM_SIZE_W; mem_addr = 32'h108; arready = 0;
    @(negedge clk); #1;
    chk("rstrd_arvalid_before", arvalid, 1);
    #1;
    resetn = 0; mem_req = 0;
    #1 chk("rstrd_arvalid", arvalid, 0);
    chk("rstrd_stall", stall, 0);
    chk("rstrd_rready", rready, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk); #1;
    chk("rstrd_idle_arvalid", arvalid, 0);
    chk("rstrd_idle_rready", rready, 0);
    load_seq(32'h10C, MEM_SIZE_W, 0, 32'h01234567, RESP_OKAY, 32'h01234567, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Sequences MEM-stage load/store instructions onto the core's AXI-Lite data master port and stalls the pipeline until each access completes.
- Sits between the MEM stage and the SoC AXI-Lite interconnect.
- Generates byte strobes and store-data replication.
- Extracts and extends load data for the MEM-stage writeback mux.
- One outstanding transaction at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; strobe logic assumes 4 bytes)

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
mem_req_i  in  1  MEM stage holds a load/store
mem_we_i  in  1  1=store, 0=load
mem_size_i  in  2  0=byte, 1=half, 2=word (3 reserved, treated as word)
mem_sign_i  in  1  sign-extend load result
mem_addr_i  in  32  byte address
mem_wdata_i  in  32  store data, right-justified
stall_o  out  1  freeze pipeline up to and including MEM
load_data_o  out  32  extended load result, valid with load_valid_o
load_valid_o  out  1  one-cycle pulse, load result ready
addr_err_o  out  1  combinational misalignment flag
bus_err_o  out  1  one-cycle pulse, non-OKAY resp on completed access
awaddr/awvalid/awready  out/out/in  32/1/1  AXI-Lite write address
wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI-Lite write data
bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite write response
araddr/arvalid/arready  out/out/in  32/1/1  AXI-Lite read address
rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI-Lite read data

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - All valid/ready outputs, stall_o, load_valid_o and bus_err_o are 0.
  - awaddr/araddr/wdata/wstrb/load_data_o are 0.
  - Reset mid-transaction abandons the transaction; system-wide reset is assumed.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - addr_err_o = mem_req_i & misaligned, combinational.
  - No bus access and no stall; the exception unit handles it.
- FSM states: IDLE, RD, WR, DONE.
- IDLE, when mem_req_i & !misaligned:
  - Latch address, strobe, store data, size and sign.
  - Load: arvalid<=1, go to RD.
  - Store: awvalid<=1 and wvalid<=1, go to WR.
- RD:
  - arvalid drops the cycle after arready&arvalid.
  - rready=1 throughout RD.
  - On rvalid&rready: register the extended load data, go to DONE.
- WR:
  - awvalid and wvalid each drop independently after their own handshake.
  - bready=1 once both handshakes are done.
  - On bvalid&bready: go to DONE.
- DONE: lasts one cycle, stall_o=0, then returns to IDLE unconditionally.
  - load_valid_o=1 in DONE if the access was a load.
  - bus_err_o=1 in DONE if the captured resp!=2'b00.
  - The pipeline advances at the end of DONE; the same request is never relaunched.
- stall_o = (IDLE & mem_req_i & !misaligned) | RD | WR.
- Store strobes and data:
  - byte: wstrb=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - half: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{wd[15:0]}}.
  - word: wstrb=4'b1111, wdata=wd.
- Load extraction: shifted = rdata>>(8*addr[1:0]).
  - Take the low 8/16/32 bits of shifted.
  - Sign- or zero-extend per mem_sign_i; word ignores sign.
- awaddr/araddr carry the full latched byte address.
- Minimum latency with a zero-wait slave:
  - Load: stall 3 cycles (accept, AR, R), DONE on the 4th.
  - Store: stall 3 cycles (accept, AW+W, B), DONE on the 4th.
- Slave back-pressure extends RD/WR indefinitely.
- AW and W may complete in either order or in the same cycle.

Decomposition:
- Shared package/header mem_bus_defs.vh:
  - Size codes MEM_SIZE_B/H/W.
  - AXI resp codes RESP_OKAY/SLVERR/DECERR.
  - FSM state encodings.
- Sub-module mem_lane_align (combinational): strobe and store-data replication, plus load shift/extend. It is shared by both paths and unit-testable.

Test Plan:
- lw addr 0x100, slave returns 0x89ABCDEF with zero wait → stall_o high 3 cycles, load_valid_o pulse, load_data_o=0x89ABCDEF.
- lb signed addr 0x103, rdata=0x80FF1234 → load_data_o=0xFFFFFF80; lhu addr 0x102 same rdata → 0x000080FF.
- sb addr 0x201, wd=0x000000A5 → wstrb=4'b0010, wdata=0xA5A5A5A5; sh addr 0x202 wd=0x1234 → wstrb=4'b1100, wdata=0x12341234.
- Store with wready 3 cycles after awready, bvalid 2 cycles later → stall held until B handshake, then one DONE cycle, bready low before both AW/W done.
- lw addr 0x102 → addr_err_o=1, stall_o=0, arvalid never asserted; rresp=SLVERR on aligned lw → bus_err_o pulse in DONE.
- resetn low while in RD with arvalid=1 → arvalid, stall_o, rready go to 0 immediately; after release, FSM is in IDLE and the next lw completes normally.
